// File: rtl/qspi_rom_arbiter.sv
// qspi_rom_arbiter: two-port read arbiter and quad-I/O read sequencer for an
// external QSPI flash. Port A has priority; port B is protected from starvation.
// A request for the byte after the last one served streams on without re-addressing.
module qspi_rom_arbiter #(
    parameter int         ADDR_BITS  = 24,
    parameter int         DUMMY      = 6,
    parameter logic [7:0] CMD_BYTE   = 8'hEB,
    parameter int         STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic [ADDR_BITS-1:0] a_addr,
    output logic                 a_ack,
    input  logic                 b_req,
    input  logic [ADDR_BITS-1:0] b_addr,
    output logic                 b_ack,
    output logic [7:0]           rd_data,
    output logic                 busy,
    output logic                 sclk,
    output logic                 select,
    output logic [3:0]           io_out,
    output logic [3:0]           io_oe,
    input  logic [3:0]           io_in
);

    localparam int NIBBLES = ADDR_BITS / 4;
    localparam int LEN_CA  = (NIBBLES > 8) ? NIBBLES : 8;
    localparam int MAX_LEN = (DUMMY + 1 > LEN_CA) ? DUMMY + 1 : LEN_CA;
    localparam int CNT_W   = $clog2(MAX_LEN);
    localparam int STV_W   = $clog2(STARVE_MAX + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA_H,
        ST_DATA_L,
        ST_PARK,
        ST_DESEL
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic [ADDR_BITS-1:0] a_ptr_q, a_ptr_d;
    logic                 port_b_q, port_b_d;   // 1: port B owns the current byte
    logic [3:0]           hi_q, hi_d;
    logic                 sclk_q, sclk_d;
    logic                 select_q, select_d;
    logic [3:0]           io_out_q, io_out_d;
    logic [3:0]           io_oe_q, io_oe_d;
    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 busy_q, busy_d;

    logic                 any_req;
    logic                 b_wins;
    logic [ADDR_BITS-1:0] win_addr;
    logic                 grant;
    logic [ADDR_BITS-1:0] addr_shifted;
    logic [7:0]           cmd_shifted;

    assign any_req  = a_req | b_req;
    assign b_wins   = b_req & (~a_req | (starve_q >= STV_W'(STARVE_MAX)));
    assign win_addr = b_wins ? b_addr : a_addr;

    // Next-state, bus phase and arbitration logic.
    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        a_ptr_d      = a_ptr_q;
        port_b_d     = port_b_q;
        hi_d         = hi_q;
        sclk_d       = sclk_q;
        select_d     = select_q;
        io_out_d     = io_out_q;
        io_oe_d      = io_oe_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        rd_data_d    = rd_data_q;
        grant        = 1'b0;
        addr_shifted = a_ptr_q << {cnt_q, 2'b00};
        cmd_shifted  = CMD_BYTE << cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant    = 1'b1;
                    select_d = 1'b0;
                    a_ptr_d  = win_addr;
                    port_b_d = b_wins;
                    cnt_d    = '0;
                    sclk_d   = 1'b0;
                    io_oe_d  = 4'b0001;
                    io_out_d = {3'b000, CMD_BYTE[7]};
                    state_d  = ST_CMD;
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA_H, ST_DATA_L: begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    // Rising sclk: present the bit/nibble the next fall will carry.
                    case (state_q)
                        ST_CMD: begin
                            io_oe_d  = 4'b0001;
                            io_out_d = {3'b000, cmd_shifted[7]};
                        end
                        ST_ADDR: begin
                            io_oe_d  = 4'b1111;
                            io_out_d = addr_shifted[ADDR_BITS-1 -: 4];
                        end
                        default: begin
                            io_oe_d  = 4'b0000;
                            io_out_d = 4'b0000;
                        end
                    endcase
                end else begin
                    // Falling sclk: one phase clock done; capture read data.
                    cnt_d = cnt_q + CNT_W'(1);
                    case (state_q)
                        ST_CMD: begin
                            if (cnt_q == CNT_W'(7)) begin
                                cnt_d   = '0;
                                state_d = ST_ADDR;
                            end
                        end
                        ST_ADDR: begin
                            if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                                cnt_d   = '0;
                                state_d = ST_DUMMY;
                            end
                        end
                        ST_DUMMY: begin
                            // DUMMY+1 clocks: the extra one is the bus turnaround before
                            // the flash drives, so byte 0 lands on fall 8+NIBBLES+DUMMY+2.
                            if (cnt_q == CNT_W'(DUMMY)) begin
                                cnt_d   = '0;
                                state_d = ST_DATA_H;
                            end
                        end
                        ST_DATA_H: begin
                            hi_d    = io_in;
                            cnt_d   = '0;
                            state_d = ST_DATA_L;
                        end
                        ST_DATA_L: begin
                            rd_data_d = {hi_q, io_in};
                            a_ack_d   = ~port_b_q;
                            b_ack_d   = port_b_q;
                            a_ptr_d   = a_ptr_q + ADDR_BITS'(1);
                            cnt_d     = '0;
                            state_d   = ST_PARK;
                        end
                        default: ;
                    endcase
                end
            end

            ST_PARK: begin
                // Arbitrate first, then test the winner for a sequential hit.
                if (any_req) begin
                    if (win_addr == a_ptr_q) begin
                        grant    = 1'b1;
                        port_b_d = b_wins;
                        sclk_d   = 1'b1;
                        state_d  = ST_DATA_H;
                    end else begin
                        select_d = 1'b1;
                        io_oe_d  = 4'b0000;
                        io_out_d = 4'b0000;
                        cnt_d    = '0;
                        state_d  = ST_DESEL;
                    end
                end
            end

            ST_DESEL: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // Counts consecutive served A grants while B waits.
        if (!b_req) begin
            starve_d = '0;
        end else if (grant) begin
            starve_d = b_wins ? '0 : starve_q + STV_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            a_ptr_q   <= '0;
            port_b_q  <= 1'b0;
            hi_q      <= 4'h0;
            sclk_q    <= 1'b0;
            select_q  <= 1'b1;
            io_out_q  <= 4'h0;
            io_oe_q   <= 4'h0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            a_ptr_q   <= a_ptr_d;
            port_b_q  <= port_b_d;
            hi_q      <= hi_d;
            sclk_q    <= sclk_d;
            select_q  <= select_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign sclk    = sclk_q;
    assign select  = select_q;
    assign io_out  = io_out_q;
    assign io_oe   = io_oe_q;

endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// tb_qspi_rom_arbiter: directed and randomized reads against a QSPI flash
// emulator plus a transaction-level model of streaming and arbitration.
`timescale 1ns/1ps
module tb_qspi_rom_arbiter;

    localparam int ADDR_BITS  = 24;
    localparam int DUMMY      = 6;
    localparam int STARVE_MAX = 4;
    localparam int NIBBLES    = ADDR_BITS / 4;
    localparam int NEW_LAT    = 2 * (8 + NIBBLES + DUMMY + 3);
    localparam int STREAM_LAT = 4;
    localparam int DATA_FALL  = 8 + NIBBLES + DUMMY + 1;   // flash drives byte 0 after this fall
    localparam int DESEL_W    = 3;                         // 2 clk DESEL + 1 clk IDLE arbitration

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 a_req = 1'b0, b_req = 1'b0;
    logic [ADDR_BITS-1:0] a_addr = '0, b_addr = '0;
    logic                 a_ack, b_ack, busy, sclk, select;
    logic [7:0]           rd_data;
    logic [3:0]           io_out, io_oe;
    logic [3:0]           io_in = 4'h0;

    qspi_rom_arbiter #(
        .ADDR_BITS (ADDR_BITS),
        .DUMMY     (DUMMY),
        .CMD_BYTE  (8'hEB),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_req  (a_req),
        .a_addr (a_addr),
        .a_ack  (a_ack),
        .b_req  (b_req),
        .b_addr (b_addr),
        .b_ack  (b_ack),
        .rd_data(rd_data),
        .busy   (busy),
        .sclk   (sclk),
        .select (select),
        .io_out (io_out),
        .io_oe  (io_oe),
        .io_in  (io_in)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [4096];
    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash emulator and select monitor, evaluated away from the active edge.
    int                   falls = 0;
    int                   k;
    logic                 sclk_prev = 1'b0;
    logic                 sel_prev = 1'b1;
    logic [7:0]           seen_cmd = 8'h00;
    logic [ADDR_BITS-1:0] seen_addr = '0;
    logic [ADDR_BITS-1:0] byte_addr;
    int unsigned          sel_low_cyc = 0, sel_high_cyc = 0;
    int                   desel_cnt = 0, desel_width = 0, oe_bad = 0;

    always begin
        @(negedge clk);
        if (select && !sel_prev) begin
            sel_high_cyc = cyc;
            desel_cnt++;
        end
        if (!select && sel_prev) begin
            sel_low_cyc = cyc;
            desel_width = int'(cyc - sel_high_cyc);
        end
        if (select) begin
            falls     = 0;
            seen_cmd  = 8'h00;
            seen_addr = '0;
            io_in     = 4'h0;
        end else if (sclk_prev && !sclk) begin
            falls++;
            if (falls <= 8) begin
                seen_cmd = {seen_cmd[6:0], io_out[0]};
                if (io_oe !== 4'b0001) oe_bad++;
            end else if (falls <= 8 + NIBBLES) begin
                seen_addr = {seen_addr[ADDR_BITS-5:0], io_out};
                if (io_oe !== 4'b1111) oe_bad++;
            end else if (io_oe !== 4'b0000) begin
                oe_bad++;
            end
            if (falls >= DATA_FALL) begin
                k         = falls - DATA_FALL;
                byte_addr = seen_addr + ADDR_BITS'(k / 2);
                io_in     = (k % 2 == 0) ? rom[byte_addr[11:0]][7:4] : rom[byte_addr[11:0]][3:0];
            end
        end
        sclk_prev = sclk;
        sel_prev  = select;
    end

    // Transaction-level model: is the flash parked on a known next address?
    bit                   model_open = 1'b0;
    logic [ADDR_BITS-1:0] model_ptr = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        model_open = 1'b0;
    endtask

    task automatic read_one(input string tag, input bit port_b, input logic [ADDR_BITS-1:0] addr);
        bit          stream;
        bit          got;
        int unsigned t0;
        int          d0;
        stream = model_open && (addr == model_ptr);
        d0     = desel_cnt;
        t0     = cyc;
        if (port_b) begin
            b_req  = 1'b1;
            b_addr = addr;
        end else begin
            a_req  = 1'b1;
            a_addr = addr;
        end
        got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = a_ack || b_ack;
        end
        check({tag, "_ack"}, 32'(got), 1);
        if (got) begin
            check({tag, "_port"}, 32'(b_ack), 32'(port_b));
            check({tag, "_data"}, 32'(rd_data), 32'(rom[addr[11:0]]));
            if (stream) begin
                check({tag, "_stream_lat"}, cyc - t0, STREAM_LAT);
                check({tag, "_no_desel"}, 32'(desel_cnt - d0), 0);
            end else begin
                check({tag, "_lat"}, cyc - sel_low_cyc, NEW_LAT);
                check({tag, "_cmd"}, 32'(seen_cmd), 32'h0000_00EB);
                check({tag, "_addr"}, 32'(seen_addr), 32'(addr));
                if (model_open) check({tag, "_desel_w"}, 32'(desel_width), DESEL_W);
            end
            model_open = 1'b1;
            model_ptr  = addr + ADDR_BITS'(1);
        end else begin
            model_open = 1'b0;
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        bit                   got, exp_b, seen_ack, pb;
        int                   starve;
        logic [ADDR_BITS-1:0] ea, ra;

        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'hFFC] = 8'hF0;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_select", 32'(select), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_io_out", 32'(io_out), 0);
        check("rst_io_oe", 32'(io_oe), 0);
        check("rst_a_ack", 32'(a_ack), 0);
        check("rst_b_ack", 32'(b_ack), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_busy", 32'(busy), 0);
        do_reset();

        // Basic read, then streaming, non-sequential and wrap cases.
        read_one("basic", 1'b0, 24'h000FFC);
        check("basic_busy_park", 32'(busy), 1);
        read_one("str0", 1'b0, 24'h000100);
        read_one("str1", 1'b0, 24'h000101);
        read_one("str2", 1'b0, 24'h000102);
        read_one("nseq0", 1'b0, 24'h000010);
        read_one("nseq1", 1'b0, 24'h000020);
        read_one("wrap0", 1'b0, 24'hFFFFFF);
        read_one("wrap1", 1'b0, 24'h000000);
        read_one("b_new", 1'b1, 24'h123456);
        read_one("b_str", 1'b1, 24'h123457);

        // Randomized mix of ports, sequential and random addresses, idle gaps.
        for (int i = 0; i < 16; i++) begin
            pb = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 1) == 1) ? model_ptr : ADDR_BITS'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            read_one($sformatf("rand%0d", i), pb, ra);
        end

        // Contention: both ports stream continuously; B must win after STARVE_MAX A grants.
        do_reset();
        a_addr = 24'h000100;
        b_addr = 24'h000200;
        a_req  = 1'b1;
        b_req  = 1'b1;
        starve = 0;
        for (int n = 0; n < 10; n++) begin
            exp_b  = (starve >= STARVE_MAX);
            starve = exp_b ? 0 : starve + 1;
            ea     = exp_b ? b_addr : a_addr;
            got    = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                @(negedge clk);
                got = a_ack || b_ack;
            end
            check($sformatf("arb%0d_ack", n), 32'(got), 1);
            if (!got) break;
            check($sformatf("arb%0d_port", n), 32'(b_ack), 32'(exp_b));
            check($sformatf("arb%0d_data", n), 32'(rd_data), 32'(rom[ea[11:0]]));
            if (b_ack) b_addr = b_addr + ADDR_BITS'(1);
            else       a_addr = a_addr + ADDR_BITS'(1);
        end
        a_req = 1'b0;
        b_req = 1'b0;

        // Reset in the middle of the dummy phase.
        do_reset();
        a_req  = 1'b1;
        a_addr = 24'h000ABC;
        got    = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = !select;
        end
        check("mid_sel_low", 32'(got), 1);
        repeat (31) @(negedge clk);
        check("mid_in_dummy_oe", 32'(io_oe), 0);
        check("mid_in_dummy_sel", 32'(select), 0);
        reset = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        check("mid_rst_select", 32'(select), 1);
        check("mid_rst_io_oe", 32'(io_oe), 0);
        check("mid_rst_sclk", 32'(sclk), 0);
        check("mid_rst_busy", 32'(busy), 0);
        seen_ack = a_ack || b_ack;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_ack || b_ack) seen_ack = 1'b1;
        end
        check("mid_rst_no_ack", 32'(seen_ack), 0);
        model_open = 1'b0;
        read_one("after_rst", 1'b0, 24'h000ABC);

        check("bus_oe_protocol", 32'(oe_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
